// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-word sequencing controller.
package mem_pkg;

   localparam int WORD_W     = 8;
   localparam int DEF_NWORDS = 16;
   localparam int DEF_ADDR_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester-side ready/valid bus of mem_ctrl: single read/write requests and their completion.
interface mem_ctrl_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] wdata;
   logic              ready;
   logic              rvalid;
   logic [WORD_W-1:0] rdata;
   logic              done;
   logic              err;

   modport master (
      output req, we, addr, wdata,
      input  ready, rvalid, rdata, done, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output ready, rvalid, rdata, done, err
   );
endinterface

// File: rtl/mem_addr_dec.sv
// Combinational address decoder: one-hot word select plus in-range flag.
module mem_addr_dec
   import mem_pkg::*;
#(
   parameter int NWORDS = DEF_NWORDS,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [NWORDS-1:0] sel,
   output logic              in_range
);

   always_comb begin
      sel      = '0;
      in_range = (int'(addr) < NWORDS);
      for (int i = 0; i < NWORDS; i++) begin
         if (int'(addr) == i) sel[i] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Read/write sequencer for the 8-bit memory-word array.
// Optional write-verify pass enabled by defining MEM_CTRL_VERIFY_EN.
//
// state  | meaning
// IDLE   | ready for a request, array deselected
// ACCESS | word selected, write strobed or read data latched
// VERIFY | word re-read after a write and compared with the written data
// DONE   | done/rvalid/err pulse, array deselected
module mem_ctrl
   import mem_pkg::*;
#(
   parameter int NWORDS = DEF_NWORDS,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   mem_ctrl_if.slave                bus,
   output logic [NWORDS-1:0]        sel,
   output logic                     rw,
   output logic [WORD_W-1:0]        data_in,
   input  logic [NWORDS*WORD_W-1:0] data_out
);

`ifdef MEM_CTRL_VERIFY_EN
   localparam bit VERIFY_EN = 1'b1;
`else
   localparam bit VERIFY_EN = 1'b0;
`endif

   mem_state_t        state, next_state;
   logic              we_q;
   logic              in_range_q;
   logic              mismatch_q;
   logic [WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0] rdata_q;
   logic [WORD_W-1:0] word_mux;
   logic [NWORDS-1:0] dec_sel;
   logic              dec_in_range;
   logic              ready_c, done_c, rvalid_c, err_c;

   mem_addr_dec #(
      .NWORDS (NWORDS),
      .ADDR_W (ADDR_W)
   ) u_dec (
      .addr     (bus.addr),
      .sel      (dec_sel),
      .in_range (dec_in_range)
   );

   // The registered select is one-hot or zero, so an OR-mux returns 0 for out-of-range accesses.
   always_comb begin
      word_mux = '0;
      for (int i = 0; i < NWORDS; i++) begin
         if (sel[i]) word_mux = word_mux | data_out[i*WORD_W +: WORD_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      ready_c    = 1'b0;
      done_c     = 1'b0;
      rvalid_c   = 1'b0;
      err_c      = 1'b0;
      unique case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.req) next_state = ACCESS;
         end
         ACCESS:  next_state = (we_q && VERIFY_EN) ? VERIFY : DONE;
         VERIFY:  next_state = DONE;
         DONE: begin
            done_c     = 1'b1;
            rvalid_c   = ~we_q;
            err_c      = ~in_range_q | mismatch_q;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         in_range_q <= 1'b0;
         mismatch_q <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         sel        <= '0;
         rw         <= 1'b0;
         data_in    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req) begin
                  we_q       <= bus.we;
                  in_range_q <= dec_in_range;
                  mismatch_q <= 1'b0;
                  wdata_q    <= bus.wdata;
                  sel        <= dec_sel;
                  rw         <= bus.we & dec_in_range;
                  // data_in only moves for a real write so the bus stays quiet otherwise
                  if (bus.we && dec_in_range) data_in <= bus.wdata;
               end
            end
            ACCESS: begin
               rw <= 1'b0;
               if (next_state != VERIFY) sel <= '0;
               if (!we_q) rdata_q <= word_mux;
            end
            VERIFY: begin
               sel        <= '0;
               mismatch_q <= in_range_q && (word_mux != wdata_q);
            end
            default: ;
         endcase
      end
   end

   assign bus.ready  = ready_c;
   assign bus.done   = done_c;
   assign bus.rvalid = rvalid_c;
   assign bus.err    = err_c;
   assign bus.rdata  = rdata_q;

endmodule
